alsu_result_fifo: RTL and testbench

Downstream capture stage for the ALSU. Each cycle its `out_valid` strobe is high, the block samples the ALSU's 6-bit `out` and 16-bit `leds` and pushes them into a small synchronous FIFO as a 7-bit record: an invalid-operation flag plus the result. A consumer (scoreboard tap, UART serializer or bus slave) drains records through a valid/ready port. The block also keeps saturating counters of invalid-flagged records and of records dropped on overflow.

---
 rtl/alsu_result_fifo.sv | 102 ++++++++++
 tb/tb_alsu_result_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alsu_result_fifo.sv
// Capture FIFO behind the ALSU: records {inv_flag, out} and counts invalid and dropped records.
// Optional macro ALSU_RESULT_PARITY_EN adds the rd_parity output.
module alsu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     out_valid,
    input  logic [5:0]               out,
    input  logic [15:0]              leds,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [6:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         err_cnt,
`ifdef ALSU_RESULT_PARITY_EN
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     rd_parity
`else
    output logic [CNT_W-1:0]         drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [6:0]       mem_q [DEPTH];

    logic       inv_flag;
    logic [6:0] push_rec;
    logic       push_ok;
    logic       drop;
    logic       pop;

    assign inv_flag = (leds != 16'h0000);
    assign push_rec = {inv_flag, out};

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign level = wptr_q - rptr_q;

    // Full is judged on pre-edge occupancy, so a same-cycle pop cannot rescue a push.
    assign push_ok = out_valid && !full;
    assign drop    = out_valid && full;
    assign pop     = rd_valid && rd_ready;

    assign rd_valid = !empty;
    assign rd_data  = rd_valid ? mem_q[rptr_q[AW-1:0]] : 7'h00;
    assign err_cnt  = err_cnt_q;
    assign drop_cnt = drop_cnt_q;

`ifdef ALSU_RESULT_PARITY_EN
    assign rd_parity = ^rd_data;
`endif

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (push_ok) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
        if (push_ok && inv_flag && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset; entries are only visible once the pointers cover them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= push_rec;
        end
    end

endmodule

// File: tb/tb_alsu_result_fifo.sv
// Directed bench for alsu_result_fifo (DEPTH=8, CNT_W=8).
module tb_alsu_result_fifo;
    logic        clk;
    logic        rst;
    logic        out_valid;
    logic [5:0]  out;
    logic [15:0] leds;
    logic        rd_valid;
    logic        rd_ready;
    logic [6:0]  rd_data;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;
`ifdef ALSU_RESULT_PARITY_EN
    logic        rd_parity;
`endif

    int total = 0;
    int bad   = 0;

    alsu_result_fifo #(.DEPTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .out_valid (out_valid),
        .out       (out),
        .leds      (leds),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .err_cnt   (err_cnt),
`ifdef ALSU_RESULT_PARITY_EN
        .drop_cnt  (drop_cnt),
        .rd_parity (rd_parity)
`else
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; out_valid = 1'b0; out = 6'h00; leds = 16'h0000; rd_ready = 1'b0;
        #3;
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_level",    32'(level),    32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        chk("rst_err",      32'(err_cnt),  32'd0);
        chk("rst_drop",     32'(drop_cnt), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_full",  32'(full),  32'd0);
        chk("idle_level", 32'(level), 32'd0);

        // single push, first-word fall-through
        out_valid = 1'b1; out = 6'h2A; leds = 16'h0000;
        tick();
        out_valid = 1'b0;
        chk("single_valid", 32'(rd_valid), 32'd1);
        chk("single_data",  32'(rd_data),  32'h2A);
        chk("single_level", 32'(level),    32'd1);
`ifdef ALSU_RESULT_PARITY_EN
        chk("single_parity", 32'(rd_parity), 32'd1);
`endif
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("single_pop_empty", 32'(empty),    32'd1);
        chk("single_pop_valid", 32'(rd_valid), 32'd0);
        tick();
        chk("ready_while_empty_level", 32'(level), 32'd0);

        // invalid flag, including a single-bit leds pattern
        out_valid = 1'b1; out = 6'h00; leds = 16'hFFFF; tick();
        out = 6'h00; leds = 16'h0000; tick();
        out = 6'h3F; leds = 16'h0001; tick();
        out_valid = 1'b0; leds = 16'h0000;
        chk("inv_head0", 32'(rd_data), 32'h40);
        chk("inv_err",   32'(err_cnt), 32'd2);
        chk("inv_level", 32'(level),   32'd3);
        rd_ready = 1'b1;
        tick();
        chk("inv_head1", 32'(rd_data), 32'h00);
        tick();
        chk("inv_head2", 32'(rd_data), 32'h7F);
        tick();
        rd_ready = 1'b0;
        chk("inv_drained", 32'(empty), 32'd1);

        // overflow: 10 pushes into 8 entries
        for (int i = 1; i <= 10; i++) begin
            out_valid = 1'b1; out = 6'(i);
            tick();
        end
        out_valid = 1'b0;
        chk("ovf_full",  32'(full),     32'd1);
        chk("ovf_level", 32'(level),    32'd8);
        chk("ovf_drop",  32'(drop_cnt), 32'd2);
        chk("ovf_head",  32'(rd_data),  32'd1);

        // push while full with simultaneous pop: push dropped, oldest popped
        out_valid = 1'b1; out = 6'h15; rd_ready = 1'b1;
        tick();
        out_valid = 1'b0;
        chk("fullpp_level", 32'(level),    32'd7);
        chk("fullpp_drop",  32'(drop_cnt), 32'd3);
        chk("fullpp_full",  32'(full),     32'd0);
        for (int k = 2; k <= 8; k++) begin
            chk($sformatf("drain_%0d", k), 32'(rd_data), 32'(k));
            tick();
        end
        rd_ready = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);

        // asynchronous reset mid-operation
        out_valid = 1'b1; out = 6'h05; leds = 16'h8000; tick();
        out_valid = 1'b0; leds = 16'h0000;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(level),    32'd0);
        chk("arst_empty", 32'(empty),    32'd1);
        chk("arst_err",   32'(err_cnt),  32'd0);
        chk("arst_drop",  32'(drop_cnt), 32'd0);
        tick();
        rst = 1'b0;
        out_valid = 1'b1; out = 6'h11; tick();
        out_valid = 1'b0;
        chk("post_rst_data",  32'(rd_data), 32'h11);
        chk("post_rst_level", 32'(level),   32'd1);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        chk("post_rst_empty", 32'(empty), 32'd1);

        // 300 invalid pushes with continuous drain: saturation and pointer wrap
        rd_ready = 1'b1; out_valid = 1'b1; leds = 16'hA5A5;
        for (int i = 0; i < 300; i++) begin
            out = 6'(i);
            tick();
            chk($sformatf("sat_data_%0d", i), 32'(rd_data), 32'({1'b1, 6'(i)}));
        end
        out_valid = 1'b0; leds = 16'h0000;
        chk("sat_err",   32'(err_cnt),  32'd255);
        chk("sat_drop",  32'(drop_cnt), 32'd0);
        chk("sat_level", 32'(level),    32'd1);
        tick();
        rd_ready = 1'b0;
        chk("sat_final_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
